// File: rtl/spi_slave.sv
// SPI mode-1 (CPOL=0, CPHA=1) byte slave, with SCK, SS and MOSI synchronized into clk.
// Latency: pin edge to action is SYNC_STAGES+2 clk cycles; spi_rx_valid arrives that long after the 8th SCK fall.
// Backpressure: one-entry tx holding register with valid/ready; an empty holding register at byte start sends 0x00 and pulses underrun.
module spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int CLK_RATIO   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SCK_I,
    input  logic       SS_I,
    input  logic       IO0_I,
    output logic       IO1_O,
    output logic       IO1_T,
    input  logic [7:0] spi_tx_data,
    input  logic       spi_tx_valid,
    output logic       spi_tx_ready,
    output logic [7:0] spi_rx_data,
    output logic       spi_rx_valid,
    output logic       spi_tx_underrun,
    output logic       spi_busy
);

    // Fewer than two flops cannot resolve metastability.
    // Below four clk per SCK period, the edge pipeline cannot separate SCK edges.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("spi_slave: SYNC_STAGES must be at least 2");
    end
    if (CLK_RATIO < 4) begin : g_bad_ratio
        $error("spi_slave: CLK_RATIO below 4 cannot resolve SCK edges");
    end

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic sck_q, ss_q, mosi_q;
    logic sck_rise, sck_fall, ss_fall, ss_rise;

    logic [7:0] hold_data;
    logic       hold_full;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       io1_q;

    logic in_frame;
    logic bit_zero;

    // Synchronizer chains; SS idles high, SCK idles low (CPOL=0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK_I};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_I};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], IO0_I};
        end
    end

    // Registered edge detection; MOSI is delayed alongside so it lines up with sck_fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q    <= 1'b0;
            ss_q     <= 1'b1;
            mosi_q   <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            ss_fall  <= 1'b0;
            ss_rise  <= 1'b0;
        end else begin
            sck_q    <= sck_sync[SYNC_STAGES-1];
            ss_q     <= ss_sync[SYNC_STAGES-1];
            mosi_q   <= mosi_sync[SYNC_STAGES-1];
            sck_rise <=  sck_sync[SYNC_STAGES-1] & ~sck_q;
            sck_fall <= ~sck_sync[SYNC_STAGES-1] &  sck_q;
            ss_fall  <= ~ss_sync[SYNC_STAGES-1]  &  ss_q;
            ss_rise  <=  ss_sync[SYNC_STAGES-1]  & ~ss_q;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame state transitions on synchronized SS edges.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs: MISO is driven only inside a frame.
    always_comb begin
        IO1_T    = (state == IDLE);
        spi_busy = (state == ACTIVE);
    end

    // A frame start coinciding with the first SCK rise is handled as start-then-bit.
    assign in_frame = (state == ACTIVE) || ss_fall;
    assign bit_zero = ss_fall || (bit_cnt == 3'd0);

    // Tx holding register, shift registers, bit counter and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data       <= 8'h00;
            hold_full       <= 1'b0;
            tx_shift        <= 8'h00;
            rx_shift        <= 8'h00;
            bit_cnt         <= 3'd0;
            io1_q           <= 1'b0;
            spi_rx_data     <= 8'h00;
            spi_rx_valid    <= 1'b0;
            spi_tx_underrun <= 1'b0;
        end else begin
            spi_rx_valid    <= 1'b0;
            spi_tx_underrun <= 1'b0;

            // Accept and consume are exclusive: accept needs empty, consume needs full.
            if (spi_tx_valid && !hold_full) begin
                hold_data <= spi_tx_data;
                hold_full <= 1'b1;
            end

            if (ss_rise && state == ACTIVE) begin
                // Abort: drop the partial byte; the holding register is left alone.
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
                io1_q    <= 1'b0;
            end else if (in_frame) begin
                if (ss_fall) begin
                    bit_cnt  <= 3'd0;
                    rx_shift <= 8'h00;
                end
                if (sck_rise) begin
                    if (bit_zero) begin
                        if (hold_full) begin
                            tx_shift  <= hold_data;
                            io1_q     <= hold_data[7];
                            hold_full <= 1'b0;
                        end else begin
                            tx_shift        <= 8'h00;
                            io1_q           <= 1'b0;
                            spi_tx_underrun <= 1'b1;
                        end
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        io1_q    <= tx_shift[6];
                    end
                end else if (sck_fall) begin
                    rx_shift <= {rx_shift[6:0], mosi_q};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        spi_rx_data  <= {rx_shift[6:0], mosi_q};
                        spi_rx_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign IO1_O        = io1_q;
    assign spi_tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-1 master with SCK = clk/8.
// Expected rx bytes are queued by the stimulus and popped by an independent monitor on spi_rx_valid.
// MISO bytes, underrun pulses and reset/idle outputs are compared against hand-computed constants.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       io1_o, io1_t;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int rx_pulses = 0;
    int urun_pulses = 0;
    logic [7:0] exp_rx[$];

    spi_slave #(.SYNC_STAGES(2), .CLK_RATIO(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .SCK_I(sck), .SS_I(ss), .IO0_I(mosi),
        .IO1_O(io1_o), .IO1_T(io1_t),
        .spi_tx_data(tx_data), .spi_tx_valid(tx_valid), .spi_tx_ready(tx_ready),
        .spi_rx_data(rx_data), .spi_rx_valid(rx_valid),
        .spi_tx_underrun(tx_underrun), .spi_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest queued byte.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            rx_pulses++;
            if (exp_rx.size() == 0) begin
                check("rx_unexpected_pulse", {24'h0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
            end
        end
        if (rst_n && tx_underrun) urun_pulses++;
    end

    // Offer one byte to the holding register, waiting a bounded time for ready.
    task automatic write_tx(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", {31'h0, tx_ready}, 32'h1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // One byte, CPHA=1: change MOSI on SCK rise, sample MISO just before SCK fall.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sck  = 1'b1;
            mosi = mo[i];
            repeat (4) @(negedge clk);
            mi[i] = io1_o;
            sck = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic ss_begin();
        ss = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_in_frame", {31'h0, busy}, 32'h1);
        check("io1_t_in_frame", {31'h0, io1_t}, 32'h0);
    endtask

    task automatic ss_end();
        ss = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_io1_o"}, {31'h0, io1_o}, 32'h0);
        check({tag, "_io1_t"}, {31'h0, io1_t}, 32'h1);
        check({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'h1);
        check({tag, "_rx_data"}, {24'h0, rx_data}, 32'h0);
        check({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'h0);
        check({tag, "_underrun"}, {31'h0, tx_underrun}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    // All queued rx bytes must have arrived by now.
    task automatic drain_check(input string tag);
        repeat (20) @(negedge clk);
        check({tag, "_rx_pending"}, exp_rx.size(), 32'h0);
    endtask

    logic [7:0] mi;
    int p0, u0;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte: preload 0xA5, receive 0x3C.
        write_tx(8'hA5);
        check("ready_after_load", {31'h0, tx_ready}, 32'h0);
        p0 = rx_pulses;
        u0 = urun_pulses;
        exp_rx.push_back(8'h3C);
        ss_begin();
        xfer(8'h3C, 8, mi);
        check("miso_a5", {24'h0, mi}, 32'hA5);
        check("ready_after_byte", {31'h0, tx_ready}, 32'h1);
        ss_end();
        drain_check("t1");
        check("t1_rx_pulses", rx_pulses - p0, 32'd1);
        check("t1_underruns", urun_pulses - u0, 32'd0);

        // Three-byte frame, tx refilled as ready allows.
        p0 = rx_pulses;
        u0 = urun_pulses;
        write_tx(8'h11);
        exp_rx.push_back(8'h01);
        exp_rx.push_back(8'h80);
        exp_rx.push_back(8'hFF);
        fork
            begin
                write_tx(8'h22);
                write_tx(8'h33);
            end
        join_none
        ss_begin();
        xfer(8'h01, 8, mi);
        check("miso_11", {24'h0, mi}, 32'h11);
        xfer(8'h80, 8, mi);
        check("miso_22", {24'h0, mi}, 32'h22);
        xfer(8'hFF, 8, mi);
        check("miso_33", {24'h0, mi}, 32'h33);
        ss_end();
        drain_check("t2");
        check("t2_rx_pulses", rx_pulses - p0, 32'd3);
        check("t2_underruns", urun_pulses - u0, 32'd0);

        // Underrun: nothing loaded.
        p0 = rx_pulses;
        u0 = urun_pulses;
        exp_rx.push_back(8'h96);
        ss_begin();
        xfer(8'h96, 8, mi);
        check("miso_underrun", {24'h0, mi}, 32'h00);
        ss_end();
        drain_check("t3");
        check("t3_underruns", urun_pulses - u0, 32'd1);
        check("t3_rx_pulses", rx_pulses - p0, 32'd1);

        // Abort after four bits, then a full 0x5A frame.
        p0 = rx_pulses;
        ss_begin();
        xfer(8'hF0, 4, mi);
        ss_end();
        check("abort_no_rx", rx_pulses - p0, 32'd0);
        check("abort_idle_busy", {31'h0, busy}, 32'h0);
        exp_rx.push_back(8'h5A);
        ss_begin();
        xfer(8'h5A, 8, mi);
        ss_end();
        drain_check("t4");
        check("t4_rx_pulses", rx_pulses - p0, 32'd1);

        // Reset mid-byte with a byte waiting in the holding register.
        p0 = rx_pulses;
        ss_begin();
        write_tx(8'h44);
        xfer(8'hAA, 3, mi);
        write_tx(8'h55);
        check("pre_reset_ready", {31'h0, tx_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        ss  = 1'b1;
        sck = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_busy", {31'h0, busy}, 32'h0);
        check("post_reset_no_rx", rx_pulses - p0, 32'd0);
        write_tx(8'h69);
        exp_rx.push_back(8'hC3);
        ss_begin();
        xfer(8'hC3, 8, mi);
        check("miso_post_reset", {24'h0, mi}, 32'h69);
        ss_end();
        drain_check("t5");

        // SCK toggling with SS high is ignored.
        p0 = rx_pulses;
        for (int i = 0; i < 10; i++) begin
            sck  = ~sck;
            mosi = i[0];
            repeat (4) @(negedge clk);
            check("idle_io1_t", {31'h0, io1_t}, 32'h1);
            check("idle_busy", {31'h0, busy}, 32'h0);
        end
        sck = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_no_rx", rx_pulses - p0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on SCK_I, SS_I and IO0_I (minimum 2).
REQ-002 SHALL have parameter CLK_RATIO, default 8, the minimum clk periods per SCK period that the design supports.
REQ-003 clk  input  1  single system clock; all logic runs on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 SCK_I  input  1  SPI clock from the master (asynchronous to clk).
REQ-006 SS_I  input  1  active-low slave select from the master.
REQ-007 IO0_I  input  1  MOSI.
REQ-008 IO1_O  output  1  MISO data.
REQ-009 IO1_T  output  1  MISO tristate enable (1 = high-Z).
REQ-010 spi_tx_data  input  8  next byte to return on MISO.
REQ-011 spi_tx_valid  input  1  spi_tx_data valid.
REQ-012 spi_tx_ready  output  1  one-entry tx holding register is empty.
REQ-013 spi_rx_data  output  8  last complete byte received on MOSI.
REQ-014 spi_rx_valid  output  1  one-cycle pulse; spi_rx_data is new.
REQ-015 spi_tx_underrun  output  1  one-cycle pulse; a byte started with the holding register empty.
REQ-016 spi_busy  output  1  frame active (synchronized SS low).

Function
REQ-017 SHALL operate fixed at CPOL=0, CPHA=1: drive MISO after each SCK rising edge, sample MOSI on each SCK falling edge, MSB first.
REQ-018 SHALL synchronize SCK_I, SS_I and IO0_I through SYNC_STAGES flops, then detect edges with one additional registered stage.
REQ-019 SHALL accept a tx byte into the holding register on a cycle where spi_tx_valid and spi_tx_ready are both 1; spi_tx_ready SHALL be 0 from the next cycle until the holding register is consumed.
REQ-020 SHALL implement two states, IDLE and ACTIVE: IDLE->ACTIVE on a synchronized SS falling edge; ACTIVE->IDLE on a synchronized SS rising edge.
REQ-021 On entering ACTIVE, SHALL clear the 3-bit bit counter and drive IO1_T to 0; in IDLE, IO1_T SHALL be 1.
REQ-022 On a detected SCK rising edge with bit counter 0, if the holding register is full, SHALL load it into the tx shift register, mark the holding register empty, and drive IO1_O with bit 7.
REQ-023 In the same case with the holding register empty, SHALL load 0x00 and pulse spi_tx_underrun for one cycle.
REQ-024 On a detected SCK rising edge with bit counter nonzero, SHALL shift the tx shift register left and drive the next bit on IO1_O.
REQ-025 On a detected SCK falling edge, SHALL shift the synchronized MOSI into the rx shift register (LSB in) and increment the bit counter modulo 8.
REQ-026 On the falling edge where the bit counter wraps 7->0, SHALL update spi_rx_data and pulse spi_rx_valid in the same clk cycle as the register update; latency from IO0_I/SCK_I at the pins is SYNC_STAGES+2 clk cycles.
REQ-027 Multi-byte frames (SS held low) SHALL continue back to back; each byte boundary repeats REQ-022/023.
REQ-028 SS rising mid-byte SHALL abort: clear the bit counter, discard the partial rx byte with no spi_rx_valid, and leave the holding register unchanged; a byte already moved to the shift register is lost.
REQ-029 SCK edges SHALL be ignored in IDLE.
REQ-030 SS falling and SCK rising detected in the same cycle SHALL be treated as a frame start followed by the first bit (REQ-022 applies).
REQ-031 Correct operation is required only when the SCK period is at least CLK_RATIO clk periods; behaviour beyond that limit is undefined.

Reset
REQ-032 While rst_n=0: IO1_O=0, IO1_T=1, spi_tx_ready=1, spi_rx_data=0x00, spi_rx_valid=0, spi_tx_underrun=0, spi_busy=0, state=IDLE, all shift registers, counters and synchronizers cleared (synchronizers to SS=1, SCK=0).
REQ-033 Reset asserted mid-frame SHALL discard all in-flight data; after release, the block waits for a new SS falling edge.

Verification
REQ-034 Preload 0xA5, then the master sends one byte 0x3C (SCK = clk/8) -> MISO bits 1,0,1,0,0,1,0,1; spi_rx_data=0x3C with exactly one spi_rx_valid pulse; spi_tx_ready returns to 1 after the first SCK rising edge.
REQ-035 3-byte frame with MOSI 0x01,0x80,0xFF; tx supplies 0x11,0x22,0x33 as ready allows -> three rx_valid pulses in order, MISO returns 0x11,0x22,0x33, no underrun.
REQ-036 No tx byte loaded, 1-byte frame -> MISO all 0, one spi_tx_underrun pulse, rx still received.
REQ-037 SS deasserted after 4 SCK cycles -> no spi_rx_valid; the next full frame with 0x5A yields 0x5A.
REQ-038 rst_n pulsed low mid-byte -> all outputs at REQ-032 values immediately; the next frame is received correctly.
REQ-039 SCK toggling with SS high -> no rx_valid, IO1_T stays 1, spi_busy stays 0.
